// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the M:SS.t stopwatch.
// Pure definitions: no latency, no backpressure.
package stopwatch_pkg;

   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] D0_MAX = 4'd9;
   localparam logic [BCD_W-1:0] D1_MAX = 4'd9;
   localparam logic [BCD_W-1:0] D2_MAX = 4'd5;
   localparam logic [BCD_W-1:0] D3_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef struct packed {
      logic [BCD_W-1:0] d3;
      logic [BCD_W-1:0] d2;
      logic [BCD_W-1:0] d1;
      logic [BCD_W-1:0] d0;
   } digits_t;

   // Wraps at or above the limit so a corrupted digit snaps back to a legal value.
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d,
                                                input logic [BCD_W-1:0] max);
      return (d >= max) ? '0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer plus released-to-pressed detector for an active-low key.
// Event is asserted combinationally two edges after the key is first sampled low; no backpressure.
module key_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic press
);

   logic sync_q1;
   logic sync_q2;
   logic prev_q;

   // Flops reset to "pressed" so a key held across reset release gives no event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync_q1 <= key;
         sync_q2 <= sync_q1;
         prev_q  <= sync_q2;
      end
   end

   assign press = prev_q & ~sync_q2;

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (0:00.0..9:59.9) with start/stop and clear keys.
// Digits and tick update on the same edge; key events act two edges after sampling; no backpressure.
module bcd_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_start,
   input  logic             key_clear,
   output logic [BCD_W-1:0] d0,
   output logic [BCD_W-1:0] d1,
   output logic [BCD_W-1:0] d2,
   output logic [BCD_W-1:0] d3,
   output logic             running,
   output logic             tick
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   state_t        state_q;
   state_t        state_d;
   logic [PW-1:0] presc_q;
   digits_t       dig_q;
   digits_t       dig_inc;
   logic          start_ev;
   logic          clear_ev;

   key_edge u_key_start (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (key_start),
      .press (start_ev)
   );

   key_edge u_key_clear (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (key_clear),
      .press (clear_ev)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Clear outranks start; a start arriving with clear is dropped.
   always_comb begin
      state_d = state_q;
      if (clear_ev) begin
         state_d = IDLE;
      end else if (start_ev) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      dig_inc    = dig_q;
      dig_inc.d0 = bcd_inc(dig_q.d0, D0_MAX);
      if (dig_q.d0 >= D0_MAX) begin
         dig_inc.d1 = bcd_inc(dig_q.d1, D1_MAX);
         if (dig_q.d1 >= D1_MAX) begin
            dig_inc.d2 = bcd_inc(dig_q.d2, D2_MAX);
            if (dig_q.d2 >= D2_MAX) begin
               dig_inc.d3 = bcd_inc(dig_q.d3, D3_MAX);
            end
         end
      end
   end

   // Prescaler only advances in RUN, so PAUSE keeps the partial tenth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         dig_q   <= '0;
         running <= 1'b0;
         tick    <= 1'b0;
      end else begin
         running <= (state_d == RUN);
         tick    <= 1'b0;
         if (clear_ev) begin
            presc_q <= '0;
            dig_q   <= '0;
         end else if (state_q == RUN) begin
            if (presc_q == PMAX) begin
               presc_q <= '0;
               dig_q   <= dig_inc;
               tick    <= 1'b1;
            end else begin
               presc_q <= presc_q + 1'b1;
            end
         end
      end
   end

   assign d0 = dig_q.d0;
   assign d1 = dig_q.d1;
   assign d2 = dig_q.d2;
   assign d3 = dig_q.d3;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Stopwatch bench: tenths-count reference model checked every cycle, plus directed literal checks.
module tb_bcd_stopwatch;

   localparam int CLK_HZ  = 100;
   localparam int TICK_HZ = 10;
   localparam int DIV     = 10;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst_n = 1'b1;
   logic       key_start = 1'b1;
   logic       key_clear = 1'b1;
   logic [3:0] d0, d1, d2, d3;
   logic       running;
   logic       tick;

   int checks = 0;
   int failures = 0;
   bit done = 1'b0;

   bcd_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_start (key_start),
      .key_clear (key_clear),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .running   (running),
      .tick      (tick)
   );

   initial forever begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: elapsed time as a tenths count; a key event is the
   // sampled level two edges ago being low while three edges ago it was high.
   int m_cnt = 0;
   int m_pre = 0;
   int m_mode = 0;   // 0 idle, 1 run, 2 pause
   bit m_tick = 1'b0;
   bit hs1 = 0, hs2 = 0, hs3 = 0;
   bit hc1 = 0, hc2 = 0, hc3 = 0;
   bit sev, cev;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0; m_pre = 0; m_mode = 0; m_tick = 0;
         hs1 = 0; hs2 = 0; hs3 = 0;
         hc1 = 0; hc2 = 0; hc3 = 0;
      end else begin
         sev = hs3 && !hs2;
         cev = hc3 && !hc2;
         hs3 = hs2; hs2 = hs1; hs1 = key_start;
         hc3 = hc2; hc2 = hc1; hc1 = key_clear;
         m_tick = 0;
         if (cev) begin
            m_mode = 0; m_cnt = 0; m_pre = 0;
         end else begin
            if (m_mode == 1) begin
               if (m_pre == DIV - 1) begin
                  m_pre = 0;
                  m_cnt = (m_cnt + 1) % 6000;
                  m_tick = 1;
               end else begin
                  m_pre++;
               end
            end
            if (sev) m_mode = (m_mode == 1) ? 2 : 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!done) begin
         check("model_d0", d0, m_cnt % 10);
         check("model_d1", d1, (m_cnt / 10) % 10);
         check("model_d2", d2, (m_cnt / 100) % 6);
         check("model_d3", d3, m_cnt / 600);
         check("model_running", running, (m_mode == 1) ? 1 : 0);
         check("model_tick", tick, m_tick);
      end
   end

   task automatic press(input bit clr_k, input bit start_k);
      if (clr_k) key_clear = 1'b0;
      if (start_k) key_start = 1'b0;
      repeat (3) @(negedge clk);
      key_clear = 1'b1;
      key_start = 1'b1;
   endtask

   task automatic wait_running(input bit v, input string nm);
      int n = 0;
      while (running !== v && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(nm, running, v);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tick !== 1'b1 && n < 3 * DIV);
      if (tick !== 1'b1) check("tick_timeout", tick, 1);
   endtask

   task automatic check_digits(input string nm, input int e3, input int e2, input int e1, input int e0);
      check({nm, "_d3"}, d3, e3);
      check({nm, "_d2"}, d2, e2);
      check({nm, "_d1"}, d1, e1);
      check({nm, "_d0"}, d0, e0);
   endtask

   initial begin
      int ticks, last, n;

      // Reset without a clock, start key held low through release.
      #3 rst_n = 1'b0;
      key_start = 1'b0;
      #2;
      check_digits("reset", 0, 0, 0, 0);
      check("reset_running", running, 0);
      check("reset_tick", tick, 0);
      #5 rst_n = 1'b1;
      #2 clk_en = 1'b1;
      repeat (20) @(negedge clk);
      check("held_key_idle", running, 0);
      key_start = 1'b1;
      repeat (5) @(negedge clk);

      // Basic count: 100 cycles after running rises gives ten evenly spaced ticks.
      press(0, 1);
      wait_running(1, "basic_start");
      ticks = 0;
      last = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (tick) begin
            ticks++;
            check("tick_spacing", i - last, DIV);
            last = i;
         end
      end
      check("basic_ticks", ticks, 10);
      check_digits("basic", 0, 0, 1, 0);

      // Pause with the prescaler holding 4 at 0:00.3, then resume.
      press(1, 0);
      wait_running(0, "clear_idle");
      repeat (5) @(negedge clk);
      check_digits("cleared", 0, 0, 0, 0);
      press(0, 1);
      wait_running(1, "pause_start");
      repeat (31) @(negedge clk);
      press(0, 1);
      check("pause_running", running, 0);
      check_digits("pause", 0, 0, 0, 3);
      ticks = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tick) ticks++;
      end
      check("pause_ticks", ticks, 0);
      check_digits("pause_hold", 0, 0, 0, 3);
      press(0, 1);
      wait_running(1, "resume_run");
      wait_tick(n);
      check("resume_latency", n, 6);
      check_digits("resume", 0, 0, 0, 4);

      // Clear and start in the same cycle: clear wins.
      repeat (5) @(negedge clk);
      press(1, 1);
      wait_running(0, "both_idle");
      check_digits("both", 0, 0, 0, 0);

      // Clear on the would-be increment edge.
      repeat (5) @(negedge clk);
      press(0, 1);
      wait_running(1, "prio_start");
      repeat (17) @(negedge clk);
      press(1, 0);
      check("prio_tick", tick, 0);
      check("prio_running", running, 0);
      check_digits("prio", 0, 0, 0, 0);

      // Roll-over.
      repeat (5) @(negedge clk);
      press(0, 1);
      wait_running(1, "roll_start");
      for (int k = 0; k < 5999 && failures < 50; k++) wait_tick(n);
      check_digits("max", 9, 5, 9, 9);
      wait_tick(n);
      check_digits("roll", 0, 0, 0, 0);
      check("roll_running", running, 1);
      check("roll_tick", tick, 1);

      // Asynchronous reset mid-run at 3:27.5.
      for (int k = 0; k < 2075 && failures < 50; k++) wait_tick(n);
      check_digits("mid", 3, 2, 7, 5);
      #2 rst_n = 1'b0;
      #1;
      check_digits("areset", 0, 0, 0, 0);
      check("areset_running", running, 0);
      check("areset_tick", tick, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("after_reset_running", running, 0);
      check_digits("after_reset", 0, 0, 0, 0);
      press(0, 1);
      wait_running(1, "restart");
      repeat (3) @(negedge clk);

      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
